// File: rtl/vend_controller.sv
//------------------------------------------------------------------------------
// Module   : vend_controller
// Brief    : Vending-machine sequencer: coin credit, purchase/refund, nickel change
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vend_controller #(
    parameter int PRICE      = 100,
    parameter int MAX_CREDIT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nickel,
    input  logic       dime,
    input  logic       quarter,
    input  logic       select,
    input  logic       coin_return,
    input  logic       dispense_done,
    input  logic       change_ready,
    output logic       dispense,
    output logic       change_nickel,
    output logic       reject,
    output logic [7:0] credit,
    output logic       busy,
    output logic       accept_en
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COLLECT  = 2'd1;
    localparam logic [1:0] S_DISPENSE = 2'd2;
    localparam logic [1:0] S_CHANGE   = 2'd3;

    localparam logic [8:0] c_max_credit = 9'(MAX_CREDIT);
    localparam logic [7:0] c_price      = 8'(PRICE);
    localparam logic [7:0] c_nickel     = 8'd5;

    logic [1:0] r_state;
    logic [7:0] r_credit;
    logic       r_dispense;
    logic       r_change_nickel;
    logic       r_reject;

    logic       w_coin_any;
    logic       w_coin_one;
    logic [8:0] w_coin_val;
    logic [8:0] w_sum;
    logic       w_gate_open;
    logic       w_coin_valid;
    logic [7:0] w_credit_add;

    assign w_coin_any  = nickel | dime | quarter;
    assign w_coin_one  = (nickel ^ dime ^ quarter) & ~(nickel & dime & quarter);
    assign w_coin_val  = nickel  ? 9'd5  :
                         dime    ? 9'd10 :
                         quarter ? 9'd25 : 9'd0;
    // 9-bit sum so the ceiling compare sees the carry instead of a wrapped value
    assign w_sum        = {1'b0, r_credit} + w_coin_val;
    assign w_gate_open  = (r_state == S_IDLE) || (r_state == S_COLLECT);
    assign w_coin_valid = w_coin_one && w_gate_open && (w_sum <= c_max_credit);
    assign w_credit_add = w_coin_valid ? w_sum[7:0] : r_credit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_credit        <= 8'd0;
            r_dispense      <= 1'b0;
            r_change_nickel <= 1'b0;
            r_reject        <= 1'b0;
        end else begin
            r_change_nickel <= 1'b0;
            r_reject        <= w_coin_any && !w_coin_valid;
            case (r_state)
                S_IDLE, S_COLLECT: begin
                    // Refund outranks purchase; a same-cycle coin is folded into the refund
                    if (coin_return && ((r_credit != 8'd0) || w_coin_valid)) begin
                        r_state  <= S_CHANGE;
                        r_credit <= w_credit_add;
                    end else if (select && (r_credit >= c_price)) begin
                        r_state    <= S_DISPENSE;
                        r_credit   <= w_credit_add - c_price;
                        r_dispense <= 1'b1;
                    end else if (w_coin_valid) begin
                        r_state  <= S_COLLECT;
                        r_credit <= w_credit_add;
                    end
                end
                S_DISPENSE: begin
                    if (dispense_done) begin
                        r_dispense <= 1'b0;
                        r_state    <= (r_credit != 8'd0) ? S_CHANGE : S_IDLE;
                    end
                end
                S_CHANGE: begin
                    if (r_credit == 8'd0) begin
                        r_state <= S_IDLE;
                    end else if (change_ready) begin
                        r_credit        <= r_credit - c_nickel;
                        r_change_nickel <= 1'b1;
                        if (r_credit == c_nickel) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dispense      = r_dispense;
    assign change_nickel = r_change_nickel;
    assign reject        = r_reject;
    assign credit        = r_credit;
    assign busy          = (r_state == S_DISPENSE) || (r_state == S_CHANGE);
    assign accept_en     = ~busy;

endmodule

`default_nettype wire

// File: tb/tb_vend_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_vend_controller
// Brief    : Scoreboard bench for vend_controller
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vend_controller;

    localparam int PRICE      = 100;
    localparam int MAX_CREDIT = 200;

    logic       clk = 1'b0;
    logic       reset, nickel, dime, quarter, select, coin_return;
    logic       dispense_done, change_ready;
    logic       dispense, change_nickel, reject, busy, accept_en;
    logic [7:0] credit;

    always #5 clk = ~clk;

    vend_controller #(.PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .nickel        (nickel),
        .dime          (dime),
        .quarter       (quarter),
        .select        (select),
        .coin_return   (coin_return),
        .dispense_done (dispense_done),
        .change_ready  (change_ready),
        .dispense      (dispense),
        .change_nickel (change_nickel),
        .reject        (reject),
        .credit        (credit),
        .busy          (busy),
        .accept_en     (accept_en)
    );

    typedef struct packed {
        logic [7:0] credit;
        logic       dispense;
        logic       change_nickel;
        logic       reject;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pulses = 0;

    // Reference model: 0 idle, 1 collect, 2 dispense, 3 change
    int   m_state  = 0;
    int   m_credit = 0;
    logic m_disp   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_push();
        exp_t e;
        int   cnt, val;
        logic ok, rej, cn;
        cnt = int'(nickel) + int'(dime) + int'(quarter);
        val = nickel ? 5 : (dime ? 10 : (quarter ? 25 : 0));
        rej = 1'b0;
        cn  = 1'b0;
        if (reset) begin
            m_state = 0; m_credit = 0; m_disp = 1'b0;
        end else if (m_state <= 1) begin
            ok  = (cnt == 1) && (m_credit + val <= MAX_CREDIT);
            rej = (cnt > 0) && !ok;
            if (!ok) val = 0;
            if (coin_return && (m_credit > 0 || ok)) begin
                m_state = 3; m_credit += val;
            end else if (select && m_credit >= PRICE) begin
                m_state = 2; m_credit = m_credit + val - PRICE; m_disp = 1'b1;
            end else if (ok) begin
                m_state = 1; m_credit += val;
            end
        end else if (m_state == 2) begin
            rej = (cnt > 0);
            if (dispense_done) begin
                m_disp  = 1'b0;
                m_state = (m_credit > 0) ? 3 : 0;
            end
        end else begin
            rej = (cnt > 0);
            if (change_ready && m_credit > 0) begin
                m_credit -= 5; cn = 1'b1;
            end
            if (m_credit == 0) m_state = 0;
        end
        e.credit        = 8'(m_credit);
        e.dispense      = m_disp;
        e.change_nickel = cn;
        e.reject        = rej;
        e.busy          = (m_state >= 2);
        sb.push_back(e);
    endtask

    task automatic cyc(input logic n, input logic d, input logic q, input logic sel,
                       input logic cr, input logic dd, input logic rdy, input logic rst = 1'b0);
        exp_t e;
        nickel = n; dime = d; quarter = q; select = sel; coin_return = cr;
        dispense_done = dd; change_ready = rdy; reset = rst;
        model_push();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("credit",        32'(credit),        32'(e.credit));
        check("dispense",      32'(dispense),      32'(e.dispense));
        check("change_nickel", 32'(change_nickel), 32'(e.change_nickel));
        check("reject",        32'(reject),        32'(e.reject));
        check("busy",          32'(busy),          32'(e.busy));
        check("accept_en",     32'(accept_en),     32'(!e.busy));
        if (change_nickel) n_pulses++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic quarters(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 1, 0, 0, 0, 0);
    endtask

    // Run with change_ready pattern until idle; an expired bound is itself a failure
    task automatic drain(input int limit, input bit toggle);
        int i;
        for (i = 0; i < limit && busy; i++) cyc(0, 0, 0, 0, 0, 0, toggle ? (i % 2 == 0) : 1'b1);
        check("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_credit", 32'(credit), 32'd0);
        check("rst_accept", 32'(accept_en), 32'd1);
        cyc(0, 0, 0, 0, 1, 0, 0);              // refund with nothing inserted
        check("empty_refund_busy", 32'(busy), 32'd0);

        // Plain purchase with exact price
        quarters(4);
        check("s1_credit", 32'(credit), 32'd100);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("s1_dispense", 32'(dispense), 32'd1);
        idle(2);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("s1_idle", 32'(busy), 32'd0);

        // Purchase with 10 cents change
        quarters(4);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("s2_credit", 32'(credit), 32'd10);
        n_pulses = 0;
        cyc(0, 0, 0, 0, 0, 1, 1);
        drain(10, 1'b0);
        check("s2_pulses", 32'(n_pulses), 32'd2);

        // Ceiling and multi-coin rejection
        quarters(7);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("s3_credit185", 32'(credit), 32'd185);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("s3_rej_over", 32'(reject), 32'd1);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("s3_credit200", 32'(credit), 32'd200);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("s3_rej_full", 32'(reject), 32'd1);
        cyc(0, 0, 0, 0, 1, 0, 0);
        drain(60, 1'b0);

        // Short select, then refund with a same-cycle coin, stalled ejector
        quarters(2);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("s4_sel_ignored", 32'(credit), 32'd60);
        cyc(0, 1, 0, 0, 1, 0, 0);
        check("s4_refund70", 32'(credit), 32'd70);
        n_pulses = 0;
        drain(60, 1'b1);
        check("s4_pulses", 32'(n_pulses), 32'd14);

        // Coins while busy
        quarters(4);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, 0, 0);
        check("s5_rej_disp", 32'(reject), 32'd1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 1, 1, 0, 0);
        check("s5_rej_chg", 32'(reject), 32'd1);
        check("s5_accept", 32'(accept_en), 32'd0);
        drain(10, 1'b0);

        // Reset during dispense discards the remaining credit
        quarters(4);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("s6_credit15", 32'(credit), 32'd15);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        check("s6_disp", 32'(dispense), 32'd0);
        check("s6_credit", 32'(credit), 32'd0);
        n_pulses = 0;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 1);
        check("s6_pulses", 32'(n_pulses), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vend_controller.md
# vend_controller

Sequencing controller for the coin-operated vending machine. It accumulates coin credit and arbitrates between purchase and refund requests. It drives a product-dispense handshake and returns change one nickel at a time through a coin-ejector handshake. It sits between the coin acceptor and the dispense and ejector mechanisms, and replaces the free-running credit counter with an explicit state machine.

## Interface
- PRICE, 100: product price in cents; multiple of 5; PRICE ≤ MAX_CREDIT.
- MAX_CREDIT, 200: credit ceiling in cents; multiple of 5; ≤ 255.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- nickel, dime, quarter  in  1 each  single-cycle coin pulses (5/10/25 cents).
- select  in  1  purchase request pulse.
- coin_return  in  1  refund request pulse.
- dispense_done  in  1  dispense mechanism finished; sampled only while dispense=1.
- change_ready  in  1  coin ejector can take a nickel this cycle.
- dispense  out  1  registered; held high until dispense_done is sampled.
- change_nickel  out  1  registered; one-cycle pulse per nickel ejected.
- reject  out  1  registered; one-cycle pulse for each refused coin event.
- credit  out  8  registered current credit in cents.
- busy  out  1  high in DISPENSE or CHANGE.
- accept_en  out  1  equal to ~busy; coin acceptor gate.

## Operation
- States: IDLE (credit=0), COLLECT (credit>0), DISPENSE, CHANGE.
- Coin event: any of nickel, dime or quarter high in a cycle.
  - Valid when exactly one coin line is high, state is IDLE or COLLECT, and credit+value ≤ MAX_CREDIT.
  - A valid coin adds its value to credit.
  - Any other coin event adds nothing and produces reject=1 in the next cycle.
- IDLE/COLLECT priority (all decisions use registered credit):
  - coin_return with credit>0, or with a valid coin in the same cycle, goes to CHANGE. The same-cycle coin is added and refunded. select is ignored.
  - Otherwise, select with credit ≥ PRICE goes to DISPENSE.
    - credit_next = credit + coin − PRICE; dispense=1 next cycle.
  - select with credit < PRICE is ignored. A same-cycle coin is still added; no second chance is taken.
  - Otherwise, a valid coin gives COLLECT.
- coin_return with credit=0 and no coin is ignored.
- DISPENSE:
  - dispense held at 1; coins rejected; select and coin_return ignored.
  - On dispense_done=1, dispense drops next cycle. Go to CHANGE if credit>0, else IDLE.
- CHANGE:
  - Each cycle with change_ready=1 and credit>0: credit −= 5 and change_nickel=1 the next cycle.
  - When credit reaches 0, go to IDLE on that same edge.
  - change_ready=0 stalls with no change to credit.
  - Coins rejected; select and coin_return ignored.
- Arithmetic: 9-bit internal sum for credit+value. The compare against MAX_CREDIT prevents any wrap, so credit never exceeds MAX_CREDIT.

## Timing
- Reset (sampled high at an edge): state IDLE; credit=0, dispense=0, change_nickel=0, reject=0, busy=0, accept_en=1.
  - Reset overrides every other input, including mid-DISPENSE and mid-CHANGE. Outstanding credit is discarded.
- Latency from an input sampled at edge k:
  - credit, dispense, reject and state are updated after edge k.
  - busy and accept_en follow state in the same cycle.
- Change throughput is one nickel per cycle while change_ready is held high. A refund of N cents takes N/5 ready cycles.
- dispense_done is ignored outside DISPENSE. A dispense_done in the same cycle that dispense first rises is not possible, because dispense is registered.

## Test plan
- Reset, then quarter×4 → credit 25/50/75/100, state COLLECT. select → dispense=1 next cycle, credit=0. dispense_done → dispense=0, IDLE.
- Credit 110 (4 quarters + dime), select, dispense_done, change_ready held high → 2 change_nickel pulses on consecutive cycles, credit 10→5→0, then IDLE.
- Credit 185, quarter → reject pulse, credit stays 185. Nickel and dime high in the same cycle → reject, credit unchanged.
- Credit 60, select → ignored, credit 60. Dime + coin_return in the same cycle → CHANGE with credit 70. change_ready toggled 1,0,1 → credit decrements only on ready cycles, 14 pulses total.
- Coins during DISPENSE and during CHANGE → reject pulse each, credit unchanged, accept_en=0 throughout.
- Reset asserted mid-DISPENSE (credit 15) → next cycle dispense=0, credit=0, IDLE, accept_en=1, no change_nickel pulses.
